// File: rtl/case_4_mul_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : case_4_mul_share_arb
//  Purpose  : Round-robin shared signed DIN0_W x DIN1_W multiplier with a
//             two-stage pipeline (operand register, product register), a
//             tagged valid/ready response stream and a truncation overflow
//             flag.
//  Revision : 1.0  initial release
// ============================================================================
module case_4_mul_share_arb #(
   parameter int N_REQ  = 4,
   parameter int ID_W   = 2,
   parameter int DIN0_W = 13,
   parameter int DIN1_W = 10,
   parameter int DOUT_W = 13
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*DIN0_W-1:0]   req_din0,
   input  logic [N_REQ*DIN1_W-1:0]   req_din1,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DOUT_W-1:0]         rsp_dout,
   output logic                      rsp_ovf,
   output logic                      busy
);

   localparam int c_PROD_W = DIN0_W + DIN1_W;
   localparam int c_HI_W   = c_PROD_W - DOUT_W + 1;

   // Round-robin pointer
   logic [ID_W-1:0]          r_ptr;

   // Stage S1: operand register
   logic                     r_v1;
   logic [ID_W-1:0]          r_id1;
   logic [DIN0_W-1:0]        r_a1;
   logic [DIN1_W-1:0]        r_b1;

   // Stage S2: product register
   logic                     r_v2;
   logic [ID_W-1:0]          r_id2;
   logic [DOUT_W-1:0]        r_p2;
   logic                     r_ovf2;

   // Pipeline control and arbitration
   logic                     w_adv1;
   logic                     w_adv2;
   logic                     w_found;
   logic [ID_W-1:0]          w_win;
   logic                     w_hs;
   logic [ID_W-1:0]          w_ptr_nxt;
   logic [N_REQ-1:0]         w_ready;

   // Unpacked per-requester operands
   logic [DIN0_W-1:0]        w_a_arr [N_REQ];
   logic [DIN1_W-1:0]        w_b_arr [N_REQ];

   // Multiplier datapath
   logic [c_PROD_W-1:0]      w_a_ext;
   logic [c_PROD_W-1:0]      w_b_ext;
   logic [c_PROD_W-1:0]      w_full;
   logic [c_HI_W-1:0]        w_hi;
   logic                     w_ovf;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign w_a_arr[gi] = req_din0[gi*DIN0_W +: DIN0_W];
         assign w_b_arr[gi] = req_din1[gi*DIN1_W +: DIN1_W];
      end
   endgenerate

   // S2 frees up when empty or being drained; S1 frees up when empty or moving on
   assign w_adv2 = ~r_v2 | rsp_ready;
   assign w_adv1 = ~r_v1 | w_adv2;

   // Find the first valid requester at or after the pointer, wrapping around
   always_comb begin
      int v_sum;
      v_sum   = 0;
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         v_sum = int'(r_ptr) + k;
         if (v_sum >= N_REQ) begin
            v_sum = v_sum - N_REQ;
         end
         if (!w_found && req_valid[v_sum]) begin
            w_found = 1'b1;
            w_win   = ID_W'(v_sum);
         end
      end
   end

   // Grant only when S1 can accept; nothing is granted while reset is held
   always_comb begin
      w_ready = '0;
      if (w_found && w_adv1 && ap_rst_n) begin
         w_ready[w_win] = 1'b1;
      end
   end

   assign req_ready = w_ready;
   assign w_hs      = w_found & w_adv1 & ap_rst_n;
   assign w_ptr_nxt = (w_win == ID_W'(N_REQ - 1)) ? '0 : (w_win + 1'b1);

   // Full-width signed product; operands explicitly sign-extended to product width
   assign w_a_ext = {{DIN1_W{r_a1[DIN0_W-1]}}, r_a1};
   assign w_b_ext = {{DIN0_W{r_b1[DIN1_W-1]}}, r_b1};
   assign w_full  = w_a_ext * w_b_ext;

   // Result fits in DOUT_W only if every bit above the kept sign bit copies it
   assign w_hi  = w_full[c_PROD_W-1:DOUT_W-1];
   assign w_ovf = ~((&w_hi) | ~(|w_hi));

   // Round-robin pointer moves past the winner only on a handshake
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_ptr <= '0;
      end else if (w_hs) begin
         r_ptr <= w_ptr_nxt;
      end
   end

   // S1 operand register: load on handshake, empty when advancing without one
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_v1  <= 1'b0;
         r_id1 <= '0;
         r_a1  <= '0;
         r_b1  <= '0;
      end else if (w_adv1) begin
         r_v1 <= w_hs;
         if (w_hs) begin
            r_id1 <= w_win;
            r_a1  <= w_a_arr[w_win];
            r_b1  <= w_b_arr[w_win];
         end
      end
   end

   // S2 product register: captures the truncated product whenever it advances
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_v2   <= 1'b0;
         r_id2  <= '0;
         r_p2   <= '0;
         r_ovf2 <= 1'b0;
      end else if (w_adv2) begin
         r_v2   <= r_v1;
         r_id2  <= r_id1;
         r_p2   <= w_full[DOUT_W-1:0];
         r_ovf2 <= w_ovf;
      end
   end

   assign rsp_valid = r_v2;
   assign rsp_id    = r_id2;
   assign rsp_dout  = r_p2;
   assign rsp_ovf   = r_ovf2;
   assign busy      = r_v1 | r_v2;

endmodule
`default_nettype wire

// File: tb/tb_case_4_mul_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_case_4_mul_share_arb
//  Purpose  : Directed, table-driven bench for case_4_mul_share_arb with
//             hand-written sequences for fairness, stall, sparse requests
//             and reset during operation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_case_4_mul_share_arb;

   localparam int N_REQ  = 4;
   localparam int ID_W   = 2;
   localparam int DIN0_W = 13;
   localparam int DIN1_W = 10;
   localparam int DOUT_W = 13;

   logic                     ap_clk;
   logic                     ap_rst_n;
   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ-1:0]         req_ready;
   logic [N_REQ*DIN0_W-1:0]  req_din0;
   logic [N_REQ*DIN1_W-1:0]  req_din1;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [DOUT_W-1:0]        rsp_dout;
   logic                     rsp_ovf;
   logic                     busy;

   case_4_mul_share_arb #(
      .N_REQ  (N_REQ),
      .ID_W   (ID_W),
      .DIN0_W (DIN0_W),
      .DIN1_W (DIN1_W),
      .DOUT_W (DOUT_W)
   ) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_din0  (req_din0),
      .req_din1  (req_din1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_dout  (rsp_dout),
      .rsp_ovf   (rsp_ovf),
      .busy      (busy)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   typedef struct {
      int          idx;
      logic [12:0] a;
      logic [9:0]  b;
      logic [12:0] dout;
      logic        ovf;
   } vec_t;

   vec_t vecs [10];
   int   n_vec;
   int   n_err;
   int   grants;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic do_reset();
      ap_rst_n  = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      tick();
      ap_rst_n  = 1'b1;
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      grants    = 0;
      ap_rst_n  = 1'b0;
      req_valid = '0;
      req_din0  = '0;
      req_din1  = '0;
      rsp_ready = 1'b0;

      //            idx  A            B           dout      ovf
      vecs[0] = '{0, 13'd100,      -10'sd3,    13'h1ED4, 1'b0};
      vecs[1] = '{2, 13'h1000,     10'h200,    13'h0000, 1'b1};
      vecs[2] = '{1, 13'd64,       10'd64,     13'h1000, 1'b1};
      vecs[3] = '{3, 13'd63,       10'd65,     13'h0FFF, 1'b0};
      vecs[4] = '{1, -13'sd64,     10'd64,     13'h1000, 1'b0};
      vecs[5] = '{0, 13'd4095,     10'd511,    13'h0E01, 1'b1};
      vecs[6] = '{3, 13'h1FFF,     10'h3FF,    13'h0001, 1'b0};
      vecs[7] = '{2, 13'd0,        10'h200,    13'h0000, 1'b0};
      vecs[8] = '{1, 13'h1000,     10'd1,      13'h1000, 1'b0};
      vecs[9] = '{0, -13'sd100,    -10'sd3,    13'h012C, 1'b0};

      // Reset state, with requests present to show req_ready stays low
      req_valid = 4'hF;
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_id",    32'(rsp_id),    32'h0);
      chk("rst_rsp_dout",  32'(rsp_dout),  32'h0);
      chk("rst_rsp_ovf",   32'(rsp_ovf),   32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
      req_valid = '0;
      tick();
      ap_rst_n = 1'b1;

      // Table: one isolated request per vector, 2-cycle latency each
      rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         req_valid = '0;
         req_valid[vecs[i].idx] = 1'b1;
         req_din0[vecs[i].idx*DIN0_W +: DIN0_W] = vecs[i].a;
         req_din1[vecs[i].idx*DIN1_W +: DIN1_W] = vecs[i].b;
         #1;
         chk("tbl_req_ready", 32'(req_ready), 32'(1 << vecs[i].idx));
         tick();
         req_valid = '0;
         #1;
         chk("tbl_rsp_early", 32'(rsp_valid), 32'h0);
         chk("tbl_busy",      32'(busy),      32'h1);
         tick();
         chk("tbl_rsp_valid", 32'(rsp_valid), 32'h1);
         chk("tbl_rsp_id",    32'(rsp_id),    32'(vecs[i].idx));
         chk("tbl_rsp_dout",  32'(rsp_dout),  32'(vecs[i].dout));
         chk("tbl_rsp_ovf",   32'(rsp_ovf),   32'(vecs[i].ovf));
         tick();
      end

      // Fairness: all requesters valid, grants rotate, one result per cycle
      do_reset();
      for (int i = 0; i < N_REQ; i++) begin
         req_din0[i*DIN0_W +: DIN0_W] = 13'(i + 1);
         req_din1[i*DIN1_W +: DIN1_W] = 10'd2;
      end
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c == 8) req_valid = '0;
         #1;
         if (c < 8) chk("fair_grant", 32'(req_ready), 32'(1 << (c % 4)));
         if (c >= 2) begin
            chk("fair_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("fair_rsp_id",    32'(rsp_id),    32'((c - 2) % 4));
            chk("fair_rsp_dout",  32'(rsp_dout),  32'(2 * ((c - 2) % 4 + 1)));
         end else begin
            chk("fair_rsp_idle",  32'(rsp_valid), 32'h0);
         end
         tick();
      end
      chk("fair_drained", 32'(rsp_valid), 32'h0);

      // Backpressure: exactly two grants, then a stable stalled output
      do_reset();
      for (int i = 0; i < N_REQ; i++) begin
         req_din0[i*DIN0_W +: DIN0_W] = 13'(10 * (i + 1));
         req_din1[i*DIN1_W +: DIN1_W] = 10'h3FF;
      end
      req_valid = 4'hF;
      rsp_ready = 1'b0;
      grants    = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         grants += $countones(req_valid & req_ready);
         chk("bp_ready", 32'(req_ready), (c == 0) ? 32'h1 : ((c == 1) ? 32'h2 : 32'h0));
         if (c >= 2) begin
            chk("bp_stall_valid", 32'(rsp_valid), 32'h1);
            chk("bp_stall_id",    32'(rsp_id),    32'h0);
            chk("bp_stall_dout",  32'(rsp_dout),  32'h1FF6);
            chk("bp_stall_busy",  32'(busy),      32'h1);
         end
         tick();
      end
      chk("bp_grant_count", 32'(grants), 32'h2);
      req_valid = '0;
      rsp_ready = 1'b1;
      #1;
      chk("bp_rel_id0",   32'(rsp_id),    32'h0);
      chk("bp_rel_v0",    32'(rsp_valid), 32'h1);
      tick();
      chk("bp_rel_v1",    32'(rsp_valid), 32'h1);
      chk("bp_rel_id1",   32'(rsp_id),    32'h1);
      chk("bp_rel_dout1", 32'(rsp_dout),  32'h1FEC);
      tick();
      chk("bp_rel_empty", 32'(rsp_valid), 32'h0);
      chk("bp_rel_busy",  32'(busy),      32'h0);

      // Sparse: move pointer to 2, then req1+req3 -> req3 first, then req1
      do_reset();
      rsp_ready = 1'b1;
      req_valid = 4'b0010;
      #1;
      chk("sp_first", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'b1010;
      #1;
      chk("sp_req3", 32'(req_ready), 32'h8);
      tick();
      req_valid = 4'b0010;
      #1;
      chk("sp_req1", 32'(req_ready), 32'h2);
      chk("sp_rsp_a", 32'(rsp_id), 32'h1);
      tick();
      req_valid = '0;
      #1;
      chk("sp_rsp_b", 32'(rsp_id), 32'h3);
      tick();
      chk("sp_rsp_c", 32'(rsp_id), 32'h1);
      chk("sp_rsp_cv", 32'(rsp_valid), 32'h1);
      tick();
      req_valid = 4'hF;
      #1;
      chk("sp_ptr_end", 32'(req_ready), 32'h4);
      req_valid = '0;
      tick();

      // Reset mid-flight: fill both stages, then pulse reset between edges
      do_reset();
      req_valid = 4'hF;
      rsp_ready = 1'b0;
      tick();
      tick();
      chk("mr_full_busy",  32'(busy),      32'h1);
      chk("mr_full_valid", 32'(rsp_valid), 32'h1);
      #2;
      ap_rst_n = 1'b0;
      #1;
      chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mr_busy",      32'(busy),      32'h0);
      chk("mr_ready",     32'(req_ready), 32'h0);
      tick();
      ap_rst_n  = 1'b1;
      req_valid = 4'b1110;
      #1;
      chk("mr_first_grant", 32'(req_ready), 32'h2);
      chk("mr_no_partial",  32'(rsp_valid), 32'h0);
      req_valid = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
